// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared opcode/funct constants and MD timer state encoding
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True for the four R-type functs that launch the MULT/DIV unit.
  function automatic logic is_md_start(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_RTYPE) &&
           ((funct == FN_MULT) || (funct == FN_MULTU) ||
            (funct == FN_DIV)  || (funct == FN_DIVU));
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// rtl/md_busy_timer.sv - MULT/DIV latency timer producing md_busy and a md_done pulse
module md_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_i,
  output logic md_busy_o,
  output logic md_done_o
);

  localparam logic [5:0] RELOAD = 6'(MD_LATENCY - 1);

  md_state_e  state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  // State, down-counter and done pulse registers; reset may land mid-operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next state: a new start always restarts the count, so an abandoned op never signals done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (md_start_i) begin
          cnt_d   = RELOAD;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (md_start_i) begin
          cnt_d = RELOAD;
        end else if (cnt_q == 6'd1) begin
          cnt_d   = 6'd0;
          state_d = MD_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  assign md_busy_o = (state_q == MD_BUSY);
  assign md_done_o = done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch-flush / MULT-DIV interlock control with stall counter
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  id_opcode,
  input  logic [5:0]  id_funct,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [5:0]  ex_opcode,
  input  logic [5:0]  ex_funct,
  input  logic [4:0]  ex_rt,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic        ex_jump,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cycles
);

  logic        id_uses_rt;
  logic        id_reads_md;
  logic        ex_md_start;
  logic        load_use;
  logic        md_hazard;
  logic        flush;
  logic [15:0] stall_q, stall_d;

  md_busy_timer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_start_i (ex_md_start),
    .md_busy_o  (md_busy),
    .md_done_o  (md_done)
  );

  // Decode which ID instructions read rt / HI-LO, and whether EX launches MULT/DIV.
  always_comb begin
    id_uses_rt  = (id_opcode == OP_RTYPE) || (id_opcode == OP_BEQ) ||
                  (id_opcode == OP_BNE)   || (id_opcode == OP_SW);
    id_reads_md = (id_opcode == OP_RTYPE) &&
                  ((id_funct == FN_MFHI) || (id_funct == FN_MFLO) ||
                   is_md_start(id_opcode, id_funct));
    ex_md_start = is_md_start(ex_opcode, ex_funct);
  end

  // Hazard priority: a flush wins because the ID instruction is on the wrong path.
  always_comb begin
    load_use    = ex_memread && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    md_hazard   = md_busy && id_reads_md;
    flush       = ex_branch_taken || ex_jump;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use || md_hazard) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Stall counter next value: count frozen-PC cycles, sticking at all ones.
  always_comb begin
    stall_d = stall_q;
    if (!pc_we && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It watches the instruction in ID and the instruction held in the ID/EX register, and generates the PC write enable, IF/ID write enable, IF/ID flush and ID/EX bubble controls. It covers three cases: load-use stalls, taken-branch/jump flushes, and interlocks against the multi-cycle MULT/DIV unit. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MD_LATENCY, 32, cycles the MULT/DIV unit needs before HI/LO are valid (legal range 2..63)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_opcode  in  6  opcode of instruction in ID
- id_funct  in  6  funct of instruction in ID
- id_rs  in  5  rs field in ID
- id_rt  in  5  rt field in ID
- ex_opcode  in  6  opcode_out of ID/EX
- ex_funct  in  6  funct_out of ID/EX
- ex_rt  in  5  rt_out of ID/EX
- ex_memread  in  1  MemRead_out of ID/EX
- ex_branch_taken  in  1  Branch_out AND ALU zero, resolved in EX
- ex_jump  in  1  Jump_out of ID/EX
- pc_we  out  1  PC load enable
- ifid_we  out  1  IF/ID load enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  zero all ID/EX control bits on next edge
- md_busy  out  1  MULT/DIV result pending
- md_done  out  1  one-cycle pulse when HI/LO become valid
- stall_cycles  out  16  count of cycles with pc_we=0, saturating

## Operation
- Decode rules:
  - id_uses_rt = R-type (opcode 0) or beq (0x04) or bne (0x05) or sw (0x2B).
  - id_reads_md = opcode 0 and funct in {0x10 MFHI, 0x12 MFLO, 0x18, 0x19, 0x1A, 0x1B}.
  - ex_md_start = ex_opcode 0 and ex_funct in {0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU}.
- Load-use hazard = ex_memread and ex_rt≠0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
- MD hazard = md_busy and id_reads_md.
- Flush = ex_branch_taken or ex_jump.
- Priority, highest first:
  - Flush: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1. Any hazard in ID is ignored because that instruction is wrong-path.
  - Load-use or MD hazard: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1.
  - Otherwise: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
- MD timer FSM, with a 6-bit down-counter:
  - IDLE: on ex_md_start, load counter=MD_LATENCY-1 and go to BUSY.
  - BUSY: decrement each cycle. When counter==1, the next edge goes to IDLE and md_done=1 for that following cycle.
  - BUSY with ex_md_start again: reload to MD_LATENCY-1 and stay in BUSY. No md_done for the abandoned operation.
- md_busy = (state==BUSY).
- A flush never cancels the timer. The instruction in EX is always older than the branch.
- stall_cycles increments on every edge where pc_we=0. It holds at 0xFFFF.

## Timing
- All control outputs are combinational from the current inputs and registered state. The consuming registers act on them at the next rising edge.
- A load-use stall lasts exactly 1 cycle: the bubble clears ex_memread on the following edge.
- An MD stall lasts until md_busy falls. An id_reads_md instruction issues in the cycle md_done=1.
- MD latency: ex_md_start seen at edge N means md_busy=1 for cycles N+1 .. N+MD_LATENCY-1, and md_done=1 in cycle N+MD_LATENCY.
- Reset values (rst_n low, asynchronous, any cycle including mid-BUSY):
  - state IDLE, counter 0, md_busy 0, md_done 0, stall_cycles 0.
  - pc_we 1, ifid_we 1, ifid_flush 0, idex_bubble 0 (given idle inputs).
- Reset release: first decision on the first rising edge after rst_n high.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - opcode/funct localparams (OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW, FN_MFHI, FN_MFLO, FN_MULT..FN_DIVU)
  - the 1-bit MD state encoding (MD_IDLE, MD_BUSY)
  - the same constants are reused by the control unit
- One sub-module: md_busy_timer, containing the FSM, counter, md_busy and md_done. The hazard/priority logic and stall counter stay in hazard_ctrl.

## Test plan
- **Load-use on rs**: lw $t0 in EX (ex_memread=1, ex_rt=8), add with id_rs=8 in ID -> one cycle of pc_we=0, ifid_we=0, idex_bubble=1; stall_cycles 0->1.
- **$zero and non-rt users**: ex_rt=0 with id_rs=0 -> no stall. addi (opcode 0x08) with id_rt==ex_rt -> no stall.
- **Flush beats stall**: ex_branch_taken=1 together with a load-use match -> pc_we=1, ifid_flush=1, idex_bubble=1; stall_cycles unchanged.
- **MD interlock**: MULTU in EX at edge N with MD_LATENCY=4, then mflo in ID -> stall in cycles N+1..N+3, md_done in N+4, mflo issues at N+4; stall_cycles=3.
- **Reset mid-BUSY**: assert rst_n=0 asynchronously two cycles after a DIV start -> md_busy drops to 0 immediately; no md_done after release; counter 0.
- **Saturation**: hold a load-use stall for 70000 cycles -> stall_cycles stays at 0xFFFF.
